// File: rtl/uart_pkg.sv
// Shared UART constants: receive FIFO entry layout (data word plus parity and framing flags).
package uart_pkg;

    localparam int RXF_DATA_W   = 8;
    localparam int RXF_ENTRY_W  = RXF_DATA_W + 2;
    localparam int RXF_PERR_BIT = RXF_DATA_W;
    localparam int RXF_FERR_BIT = RXF_DATA_W + 1;

endpackage

// File: rtl/rx_fifo_mem.sv
// Register-array storage for the receive FIFO.
// It has one synchronous write port and one asynchronous read port, and no reset.
module rx_fifo_mem #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO behind the UART receiver.
// It stores each word with its error flags and sets a sticky overrun flag when a word is dropped.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATAWIDTH = RXF_DATA_W,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATAWIDTH-1:0]   rx_data,
    input  logic                   rx_done,
    input  logic                   parity_err,
    input  logic                   framing_err,
    input  logic                   par_en,
    input  logic                   rd_en,
    output logic [DATAWIDTH-1:0]   rd_data,
    output logic                   rd_perr,
    output logic                   rd_ferr,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun,
    input  logic                   clr_overrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATAWIDTH + 2;

    logic          rx_done_q;
    logic          primed;
    logic          wr_ev;
    logic          pop;
    logic          push;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head;

    // primed blocks writes on the first clock after reset, so a level already high on rx_done is not taken as an edge.
    assign wr_ev    = rx_done & ~rx_done_q & primed;
    assign pop      = rd_en & ~empty;
    assign push     = wr_ev & (~full | pop);
    assign wr_entry = {framing_err, parity_err & par_en, rx_data};
    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_done_q <= 1'b0;
            primed    <= 1'b0;
        end else begin
            rx_done_q <= rx_done;
            primed    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // A new overrun takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (wr_ev && full && !pop) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    rx_fifo_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign rd_data = empty ? '0 : head[DATAWIDTH-1:0];
    assign rd_perr = ~empty & head[DATAWIDTH];
    assign rd_ferr = ~empty & head[DATAWIDTH+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo.
// A queue-based model predicts every output on each cycle; directed literal checks pin the model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       parity_err;
    logic       framing_err;
    logic       par_en;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_perr;
    logic       rd_ferr;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overrun;
    logic       clr_overrun;

    int vectors    = 0;
    int miscompares = 0;

    logic [9:0] q[$];
    logic       m_ovr      = 1'b0;
    logic       m_done_q   = 1'b0;
    logic       m_primed   = 1'b0;

    uart_rx_fifo #(.DATAWIDTH(8), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .par_en      (par_en),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_perr     (rd_perr),
        .rd_ferr     (rd_ferr),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    // Reference model: the FIFO as a queue of {ferr, perr, data}, updated from the rules of each clock edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_ovr    = 1'b0;
            m_done_q = 1'b0;
            m_primed = 1'b0;
        end else begin
            automatic logic ev       = rx_done && !m_done_q && m_primed;
            automatic logic was_full = (q.size() == DEPTH);
            automatic logic do_pop   = rd_en && (q.size() != 0);
            automatic logic set_ovr  = ev && was_full && !do_pop;
            if (do_pop) void'(q.pop_front());
            if (ev && !set_ovr) q.push_back({framing_err, parity_err && par_en, rx_data});
            if (clr_overrun) m_ovr = 1'b0;
            if (set_ovr) m_ovr = 1'b1;
            m_done_q = rx_done;
            m_primed = 1'b1;
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        automatic logic [9:0] hd = (q.size() != 0) ? q[0] : 10'h0;
        check_output("rd_data", 32'(rd_data), 32'(hd[7:0]));
        check_output("rd_perr", 32'(rd_perr), 32'(hd[8]));
        check_output("rd_ferr", 32'(rd_ferr), 32'(hd[9]));
        check_output("empty",   32'(empty),   32'(q.size() == 0));
        check_output("full",    32'(full),    32'(q.size() == DEPTH));
        check_output("count",   32'(count),   32'(q.size()));
        check_output("overrun", 32'(overrun), 32'(m_ovr));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d, input logic pe, input logic fe, input logic pen);
        rx_data     = d;
        parity_err  = pe;
        framing_err = fe;
        par_en      = pen;
        rx_done     = 1'b1;
        tick();
        rx_done     = 1'b0;
        tick();
    endtask

    task automatic apply_stimulus(input int rd_pct);
        rx_done     = 1'($urandom_range(0, 1));
        rx_data     = 8'($urandom);
        parity_err  = 1'($urandom_range(0, 1));
        framing_err = 1'($urandom_range(0, 1));
        par_en      = 1'($urandom_range(0, 1));
        rd_en       = ($urandom_range(0, 99) < rd_pct);
        clr_overrun = ($urandom_range(0, 19) == 0);
        tick();
    endtask

    initial begin
        rst = 1'b0;
        rx_data = 8'h0; rx_done = 1'b0; parity_err = 1'b0; framing_err = 1'b0;
        par_en = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (3) tick();
        check_output("reset_empty", 32'(empty), 32'd1);
        check_output("reset_count", 32'(count), 32'd0);
        rst = 1'b1;
        tick();

        write_word(8'hA5, 1'b1, 1'b0, 1'b1);
        check_output("t2_data", 32'(rd_data), 32'hA5);
        check_output("t2_perr", 32'(rd_perr), 32'd1);
        check_output("t2_ferr", 32'(rd_ferr), 32'd0);
        check_output("t2_count", 32'(count), 32'd1);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        check_output("t2_empty", 32'(empty), 32'd1);
        check_output("t2_data0", 32'(rd_data), 32'h0);

        rx_data = 8'h3C; parity_err = 1'b1; par_en = 1'b0; framing_err = 1'b0;
        rx_done = 1'b1;
        repeat (5) tick();
        rx_done = 1'b0;
        tick();
        check_output("t3_count", 32'(count), 32'd1);
        check_output("t3_data", 32'(rd_data), 32'h3C);
        check_output("t3_perr", 32'(rd_perr), 32'd0);
        rd_en = 1'b1; tick(); rd_en = 1'b0;

        for (int i = 0; i < 16; i++) write_word(8'(i), 1'b0, 1'b0, 1'b0);
        check_output("t4_full", 32'(full), 32'd1);
        check_output("t4_count16", 32'(count), 32'd16);
        write_word(8'hFF, 1'b0, 1'b1, 1'b0);
        check_output("t4_overrun", 32'(overrun), 32'd1);
        check_output("t4_count_keep", 32'(count), 32'd16);
        rd_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_output("t4_drain", 32'(rd_data), 32'(i));
            tick();
        end
        rd_en = 1'b0;
        check_output("t4_drained", 32'(empty), 32'd1);
        clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
        check_output("t4_clr", 32'(overrun), 32'd0);

        for (int i = 0; i < 3; i++) write_word(8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
        rx_data = 8'h13; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        tick();
        check_output("t5_count3", 32'(count), 32'd3);
        check_output("t5_order", 32'(rd_data), 32'h11);
        for (int i = 0; i < 13; i++) write_word(8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
        check_output("t5_full", 32'(full), 32'd1);
        rx_data = 8'h55; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        check_output("t5_no_ovr", 32'(overrun), 32'd0);
        check_output("t5_count16", 32'(count), 32'd16);
        rd_en = 1'b1; repeat (15) tick(); rd_en = 1'b0;
        check_output("t5_last", 32'(rd_data), 32'h55);
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        rx_data = 8'h77; rx_done = 1'b1; rd_en = 1'b1;
        tick();
        rx_done = 1'b0; rd_en = 1'b0;
        check_output("t5_empty_wr", 32'(count), 32'd1);
        check_output("t5_empty_data", 32'(rd_data), 32'h77);

        for (int i = 0; i < 4; i++) write_word(8'hC0 + 8'(i), 1'b1, 1'b1, 1'b1);
        rx_data = 8'hEE; rx_done = 1'b1;
        rst = 1'b0;
        #1;
        check_output("t1_count", 32'(count), 32'd0);
        check_output("t1_empty", 32'(empty), 32'd1);
        check_output("t1_full", 32'(full), 32'd0);
        check_output("t1_data", 32'(rd_data), 32'h0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check_output("t1_held_no_wr", 32'(count), 32'd0);
        rx_done = 1'b0;
        tick();

        for (int i = 0; i < 400; i++) begin
            case (i / 100)
                0: apply_stimulus(15);
                1: apply_stimulus(85);
                2: apply_stimulus(50);
                default: apply_stimulus(30);
            endcase
        end
        rx_done = 1'b0; rd_en = 1'b1; clr_overrun = 1'b0;
        repeat (20) tick();
        rd_en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
